// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage (main + skid) with registered in_ready, flush and a
// saturating stall counter.
module pipe_stage_reg #(
    parameter int WIDTH         = 161,
    parameter bit CLEAR_PAYLOAD = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] stall_q;
    logic             in_xfer, out_xfer;

    // Handshake outputs depend only on registered state, so there is no
    // combinational path from out_ready back to in_ready.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign out_data  = main_q;
    assign stall_cnt = stall_q;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            if (CLEAR_PAYLOAD) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                        if (CLEAR_PAYLOAD) main_d = '0;
                    end else if (in_xfer) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Counts backpressure cycles; flush neither counts nor clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: stimulus pushes expected outputs into a
// queue, a negedge monitor pops and compares on every output transfer.
module tb_pipe_stage_reg;

    localparam int W = 161;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic [1:0]   occupancy;
    logic [15:0]  stall_cnt;

    logic         flush2;
    logic         in_valid2;
    logic [7:0]   in_data2;
    logic         in_ready2;
    logic         out_valid2;
    logic [7:0]   out_data2;
    logic         out_ready2;
    logic [1:0]   occupancy2;
    logic [3:0]   stall_cnt2;

    int vectors     = 0;
    int miscompares = 0;
    logic [W-1:0] sb[$];

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.WIDTH(8), .CLEAR_PAYLOAD(1'b1), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush2),
        .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready2),
        .occupancy(occupancy2), .stall_cnt(stall_cnt2)
    );

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output: got %0h expected no output", out_data);
            end else begin
                chk("sb_data", out_data, sb.pop_front());
            end
        end
    end

    localparam logic [W-1:0] DA  = 161'h0_CAFE0001_CAFE0002_CAFE0003_CAFE0004_000000AB;
    localparam logic [W-1:0] DB  = 161'h1_11111111_22222222_33333333_44444444_000000BB;
    localparam logic [W-1:0] DC  = 161'h0_55555555_66666666_77777777_88888888_000000CC;
    localparam logic [W-1:0] DD  = 161'h1_9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000_000000DD;
    localparam logic [W-1:0] DE  = 161'h0_12345678_9ABCDEF0_0FEDCBA9_87654321_000000EE;
    localparam logic [W-1:0] DF  = 161'h1_00000000_00000000_00000000_00000001_000000FF;

    initial begin
        logic [W-1:0] d;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        flush2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_occupancy", W'(occupancy), W'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_stall_cnt", W'(stall_cnt), W'(0));
        tick(); tick();
        reset = 1'b1;

        // single transfer, one-cycle latency, NOP payload when empty
        in_valid = 1'b1; in_data = DA; out_ready = 1'b1; sb.push_back(DA);
        tick();
        chk("lat_out_valid", W'(out_valid), W'(1));
        chk("lat_out_data", out_data, DA);
        chk("lat_occupancy", W'(occupancy), W'(1));
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", W'(out_valid), W'(0));
        chk("drain_out_data", out_data, '0);

        // backpressure fills skid, then drains in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DA; sb.push_back(DA);
        tick();
        chk("bp_occ1", W'(occupancy), W'(1));
        in_data = DB; sb.push_back(DB);
        tick();
        chk("bp_occ2", W'(occupancy), W'(2));
        chk("bp_in_ready0", W'(in_ready), W'(0));
        in_data = DC;
        tick();
        chk("bp_hold_occ2", W'(occupancy), W'(2));
        chk("bp_stall2", W'(stall_cnt), W'(2));
        sb.push_back(DC);
        out_ready = 1'b1;
        tick();
        chk("bp_after_pop_occ", W'(occupancy), W'(1));
        tick();
        in_valid = 1'b0;
        tick();
        chk("bp_done_occ", W'(occupancy), W'(0));
        chk("bp_done_stall", W'(stall_cnt), W'(2));

        // flush from TWO discards both entries and the concurrent input
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DA; sb.push_back(DA);
        tick();
        in_data = DB; sb.push_back(DB);
        tick();
        chk("fl_pre_occ", W'(occupancy), W'(2));
        chk("fl_pre_stall", W'(stall_cnt), W'(3));
        flush = 1'b1; in_data = DC;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        chk("fl_occ", W'(occupancy), W'(0));
        chk("fl_out_valid", W'(out_valid), W'(0));
        chk("fl_out_data", out_data, '0);
        chk("fl_stall", W'(stall_cnt), W'(3));
        out_ready = 1'b1;
        tick(); tick();
        chk("fl_no_output", W'(out_valid), W'(0));

        // full-rate streaming
        for (int i = 0; i < 100; i++) begin
            d = W'(i + 256);
            in_valid = 1'b1; in_data = d; sb.push_back(d);
            tick();
            chk("stream_occ", W'(occupancy), W'(1));
        end
        in_valid = 1'b0;
        tick(); tick();
        chk("stream_drained", W'(sb.size()), W'(0));
        chk("stream_stall", W'(stall_cnt), W'(3));

        // async reset while holding two entries
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DD; sb.push_back(DD);
        tick();
        in_data = DE; sb.push_back(DE);
        tick();
        in_valid = 1'b0;
        tick();
        chk("ar_pre_occ", W'(occupancy), W'(2));
        chk("ar_pre_stall", W'(stall_cnt), W'(5));
        #2 reset = 1'b0;
        #1;
        chk("ar_out_valid", W'(out_valid), W'(0));
        chk("ar_occ", W'(occupancy), W'(0));
        chk("ar_in_ready", W'(in_ready), W'(1));
        chk("ar_out_data", out_data, '0);
        chk("ar_stall", W'(stall_cnt), W'(0));
        sb.delete();
        out_ready = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("ar_post_out_valid", W'(out_valid), W'(0));

        // first edge after reset release transfers
        in_valid = 1'b1; in_data = DF; sb.push_back(DF);
        tick();
        chk("rr_out_valid", W'(out_valid), W'(1));
        chk("rr_out_data", out_data, DF);
        in_valid = 1'b0;
        tick();
        chk("rr_drained", W'(sb.size()), W'(0));

        // 4-bit stall counter saturation
        in_valid2 = 1'b1; in_data2 = 8'h5A;
        tick();
        in_valid2 = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("sat_mid", W'(stall_cnt2), W'(10));
        for (int i = 0; i < 10; i++) tick();
        chk("sat_cnt", W'(stall_cnt2), W'(15));
        chk("sat_out_valid", W'(out_valid2), W'(1));
        chk("sat_out_data", W'(out_data2), W'(8'h5A));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 161, payload width in bits (five 32-bit fields plus one flag).
REQ-002 SHALL have parameter CLEAR_PAYLOAD, default 1; 1 = payload registers zeroed on reset, flush and drain, 0 = payload holds its last value.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 flush  input  1  synchronous clear of all buffered entries (bubble insertion).
REQ-007 in_valid  input  1  upstream offers in_data.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 in_ready  output  1  stage accepts in_data this cycle.
REQ-010 out_valid  output  1  out_data holds a valid entry.
REQ-011 out_data  output  WIDTH  downstream payload.
REQ-012 out_ready  input  1  downstream consumes out_data this cycle.
REQ-013 occupancy  output  2  number of buffered entries (0..2).
REQ-014 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-015 SHALL hold a main register (drives out_data) and a skid register; state EMPTY (0 entries), ONE (main full), TWO (main and skid full).
REQ-016 in_ready SHALL equal 1 exactly when state != TWO, registered (no combinational path from out_ready).
REQ-017 out_valid SHALL equal 1 exactly when state != EMPTY; occupancy SHALL equal 0/1/2 for EMPTY/ONE/TWO.
REQ-018 Transfer in SHALL occur when in_valid=1 and in_ready=1; transfer out when out_valid=1 and out_ready=1.
REQ-019 EMPTY: in_valid=1 -> main<=in_data, ONE; else stay EMPTY.
REQ-020 ONE: in and out transfer -> main<=in_data, stay ONE; out only -> EMPTY; in only -> skid<=in_data, TWO; neither -> hold.
REQ-021 TWO: out_ready=1 -> main<=skid, ONE; out_ready=0 -> hold; no input accepted.
REQ-022 Latency SHALL be one cycle: data accepted at edge N appears on out_data after edge N when the stage was EMPTY or drained in that cycle.
REQ-023 Ordering SHALL be strictly FIFO; no entry SHALL be dropped or duplicated except by flush.
REQ-024 flush=1 SHALL take priority over all transfers: next state EMPTY, any in-transfer that cycle discarded, out-transfer in that cycle still counts as consumed by downstream.
REQ-025 With CLEAR_PAYLOAD=1, main and skid SHALL be set to 0 on flush, and main SHALL be set to 0 when the stage goes to EMPTY, so out_data=0 (NOP) whenever out_valid=0.
REQ-026 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0 and flush=0, saturate at all-ones, and not be cleared by flush.

Reset
REQ-027 While reset=0, state SHALL be EMPTY immediately (asynchronously): out_valid=0, in_ready=1, occupancy=0, out_data=0, skid=0, stall_cnt=0, regardless of CLEAR_PAYLOAD.
REQ-028 Reset deassertion SHALL be sampled at clk; first transfer SHALL be possible on the first edge after reset=1.
REQ-029 Reset asserted mid-operation (state TWO) SHALL discard both entries with no further out_valid.

Verification
REQ-030 Reset then in_valid=1 in_data=0x...AB, out_ready=1 -> next cycle out_valid=1, out_data=0x...AB, occupancy=1; next cycle with in_valid=0 -> out_valid=0, out_data=0.
REQ-031 Stream A,B,C with out_ready=0 -> occupancy 1 then 2, in_ready=0 after B, C held upstream; raise out_ready -> outputs A,B,C in order, stall_cnt=2 (cycles stalled while valid).
REQ-032 State TWO (A main, B skid), flush=1 with in_valid=1 (C) -> next cycle occupancy=0, out_data=0, C not delivered; stall_cnt unchanged.
REQ-033 Continuous in_valid=1 and out_ready=1 for 100 cycles with incrementing data -> one output per cycle, data matches input delayed one cycle, occupancy stays 1.
REQ-034 In TWO, drive reset=0 between edges -> out_valid=0 and occupancy=0 before next clk edge; stall_cnt=0.
REQ-035 CNT_W=4, hold out_valid=1 out_ready=0 for 20 cycles -> stall_cnt saturates at 15.
